contador_entrada: RTL and testbench

//   Sequential up/down counter that drives the 5-bit 'entrada' bus of the
//   7-segment display decoder, one stage upstream of it.
//   - Three push-buttons select the mode: count up, count down, or pause.
//   - A prescaler sets the step rate.
//   - saida connects straight to the decoder input; volta flags each wrap.

---
 rtl/contador_entrada_if.sv | 35 +++
 rtl/contador_entrada.sv | 122 ++++++++++++
 tb/tb_contador_entrada.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/contador_entrada_if.sv
// Button/counter bundle between the mode buttons, the up/down counter and the
// 7-segment decoder it feeds.
//   btn_sobe/btn_desce/btn_pausa : raw asynchronous push-buttons (up/down/pause)
//   saida                        : counter value, LARGO bits, to decoder 'entrada'
//   volta                        : one-clock pulse on the wrapping step
//   estado                       : mode, 00 PARADO, 01 SUBINDO, 10 DESCENDO
// master = button/display side, slave = counter.
interface contador_entrada_if #(
  parameter int unsigned LARGO = 5
) ();
  logic             btn_sobe;
  logic             btn_desce;
  logic             btn_pausa;
  logic [LARGO-1:0] saida;
  logic             volta;
  logic [1:0]       estado;

  modport master (
    output btn_sobe,
    output btn_desce,
    output btn_pausa,
    input  saida,
    input  volta,
    input  estado
  );

  modport slave (
    input  btn_sobe,
    input  btn_desce,
    input  btn_pausa,
    output saida,
    output volta,
    output estado
  );
endinterface

// File: rtl/contador_entrada.sv
// Up/down counter driving the 5-bit 'entrada' bus of the 7-segment decoder.
// Three buttons select count up, count down or pause; a prescaler of DIV
// clocks sets the step rate; volta pulses on each wrap.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : contador_entrada_if slave (buttons in; saida, volta, estado out)
// All outputs come straight from flops.
module contador_entrada #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned LARGO = 5
) (
  input  logic              clk,
  input  logic              rst,
  contador_entrada_if.slave bus
);

  localparam int unsigned   PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    PARADO   = 2'b00,
    SUBINDO  = 2'b01,
    DESCENDO = 2'b10
  } estado_t;

  estado_t          estado_q;
  logic [PW-1:0]    pre_q;
  logic [LARGO-1:0] saida_q;
  logic             volta_q;

  // Button synchronizer chain; bit 0 sobe, bit 1 desce, bit 2 pausa.
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] s3;
  logic [2:0] ev;
  logic       ev_sobe;
  logic       ev_desce;
  logic       ev_pausa;
  logic       passo;

  // One event per rising edge of the synchronized button.
  assign ev       = s2 & ~s3;
  assign ev_sobe  = ev[0];
  assign ev_desce = ev[1];
  assign ev_pausa = ev[2];

  // Prescaler terminal count: the step happens on this edge.
  assign passo = (pre_q == PRE_MAX);

  // Synchronizer, mode FSM, prescaler and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      estado_q <= PARADO;
      pre_q    <= '0;
      saida_q  <= '0;
      volta_q  <= 1'b0;
    end else begin
      s1      <= {bus.btn_pausa, bus.btn_desce, bus.btn_sobe};
      s2      <= s1;
      s3      <= s2;
      volta_q <= 1'b0;

      // Events for the current mode are filtered out by simply not being
      // listed in that mode; a mode change never steps the counter.
      unique case (estado_q)
        PARADO: begin
          pre_q <= '0;
          if (ev_sobe) begin
            estado_q <= SUBINDO;
          end else if (ev_desce) begin
            estado_q <= DESCENDO;
          end
        end

        SUBINDO: begin
          if (ev_pausa) begin
            estado_q <= PARADO;
            pre_q    <= '0;
          end else if (ev_desce) begin
            estado_q <= DESCENDO;
            pre_q    <= '0;
          end else if (passo) begin
            pre_q   <= '0;
            saida_q <= saida_q + LARGO'(1);
            volta_q <= (saida_q == '1);
          end else begin
            pre_q <= pre_q + PW'(1);
          end
        end

        DESCENDO: begin
          if (ev_pausa) begin
            estado_q <= PARADO;
            pre_q    <= '0;
          end else if (ev_sobe) begin
            estado_q <= SUBINDO;
            pre_q    <= '0;
          end else if (passo) begin
            pre_q   <= '0;
            saida_q <= saida_q - LARGO'(1);
            volta_q <= (saida_q == '0);
          end else begin
            pre_q <= pre_q + PW'(1);
          end
        end

        default: begin
          estado_q <= PARADO;
          pre_q    <= '0;
        end
      endcase
    end
  end

  assign bus.saida  = saida_q;
  assign bus.volta  = volta_q;
  assign bus.estado = estado_q;

endmodule

// File: tb/tb_contador_entrada.sv
// Directed bench for contador_entrada with DIV=4, LARGO=5.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_contador_entrada;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  contador_entrada_if #(.LARGO(5)) bus ();

  contador_entrada #(
    .DIV   (4),
    .LARGO (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [4:0] s, input logic [1:0] e, input logic v);
    chk({tag, ".saida"},  32'(bus.saida),  32'(s));
    chk({tag, ".estado"}, 32'(bus.estado), 32'(e));
    chk({tag, ".volta"},  32'(bus.volta),  32'(v));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.btn_sobe  = 1'b0;
    bus.btn_desce = 1'b0;
    bus.btn_pausa = 1'b0;

    // 1) reset and idle
    tick(2);
    rst = 1'b0;
    chk3("reset", 5'd0, 2'b00, 1'b0);
    tick(20);
    chk3("idle", 5'd0, 2'b00, 1'b0);

    // 2) sobe pulse: mode at k+2, first step at k+6, next at k+10
    bus.btn_sobe = 1'b1;
    tick(1);
    bus.btn_sobe = 1'b0;
    tick(1);
    chk3("sobe_k1", 5'd0, 2'b00, 1'b0);
    tick(1);
    chk3("sobe_k2", 5'd0, 2'b01, 1'b0);
    tick(3);
    chk3("sobe_k5", 5'd0, 2'b01, 1'b0);
    tick(1);
    chk3("sobe_k6", 5'd1, 2'b01, 1'b0);
    tick(4);
    chk3("sobe_k10", 5'd2, 2'b01, 1'b0);

    // 3) sweep up to 31, then wrap to 0 with a single-cycle volta
    for (int v = 3; v < 32; v++) begin
      tick(4);
      chk("sweep.saida", 32'(bus.saida), 32'(v));
      chk("sweep.volta", 32'(bus.volta), 32'd0);
    end
    tick(4);
    chk3("wrap_up", 5'd0, 2'b01, 1'b1);
    tick(1);
    chk3("wrap_up_after", 5'd0, 2'b01, 1'b0);

    // 4) pause at 5, hold 40 clocks, then count down
    tick(19);
    chk3("at5", 5'd5, 2'b01, 1'b0);
    bus.btn_pausa = 1'b1;
    tick(1);
    bus.btn_pausa = 1'b0;
    tick(2);
    chk3("pausa", 5'd5, 2'b00, 1'b0);
    tick(40);
    chk3("pausa_hold", 5'd5, 2'b00, 1'b0);
    bus.btn_desce = 1'b1;
    tick(1);
    bus.btn_desce = 1'b0;
    tick(2);
    chk3("desce", 5'd5, 2'b10, 1'b0);
    tick(4);
    chk3("desce_step", 5'd4, 2'b10, 1'b0);

    // down through 0 to 31 with volta
    tick(16);
    chk3("down_0", 5'd0, 2'b10, 1'b0);
    tick(4);
    chk3("wrap_down", 5'd31, 2'b10, 1'b1);
    tick(1);
    chk3("wrap_down_after", 5'd31, 2'b10, 1'b0);

    // reversal on the edge where the prescaler sits at DIV-1: no step there
    bus.btn_sobe = 1'b1;
    tick(1);
    bus.btn_sobe = 1'b0;
    tick(1);
    chk3("rev_pre", 5'd31, 2'b10, 1'b0);
    tick(1);
    chk3("rev_edge", 5'd31, 2'b01, 1'b0);
    tick(3);
    chk3("rev_wait", 5'd31, 2'b01, 1'b0);
    tick(1);
    chk3("rev_step", 5'd0, 2'b01, 1'b1);

    // 5) sobe+pausa together while SUBINDO: pausa wins
    bus.btn_sobe  = 1'b1;
    bus.btn_pausa = 1'b1;
    tick(1);
    bus.btn_sobe  = 1'b0;
    bus.btn_pausa = 1'b0;
    tick(2);
    chk3("sobe_pausa", 5'd0, 2'b00, 1'b0);

    // sobe+desce together from PARADO: sobe wins
    bus.btn_sobe  = 1'b1;
    bus.btn_desce = 1'b1;
    tick(1);
    bus.btn_sobe  = 1'b0;
    bus.btn_desce = 1'b0;
    tick(2);
    chk3("sobe_desce", 5'd0, 2'b01, 1'b0);

    bus.btn_pausa = 1'b1;
    tick(1);
    bus.btn_pausa = 1'b0;
    tick(2);
    chk3("pausa2", 5'd0, 2'b00, 1'b0);

    // sobe held 30 clocks yields one event only
    bus.btn_sobe = 1'b1;
    tick(2);
    chk("held_k1.estado", 32'(bus.estado), 32'd0);
    tick(1);
    chk("held_k2.estado", 32'(bus.estado), 32'd1);
    bus.btn_desce = 1'b1;
    tick(1);
    bus.btn_desce = 1'b0;
    tick(2);
    chk("held_desce.estado", 32'(bus.estado), 32'd2);
    tick(24);
    chk("held_30.estado", 32'(bus.estado), 32'd2);
    bus.btn_sobe = 1'b0;
    tick(4);
    chk("held_release.estado", 32'(bus.estado), 32'd2);

    // 6) reset mid-count at 17; a pending desce event is dropped
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk3("rst2", 5'd0, 2'b00, 1'b0);
    bus.btn_sobe = 1'b1;
    tick(1);
    bus.btn_sobe = 1'b0;
    tick(2);
    chk3("count17_start", 5'd0, 2'b01, 1'b0);
    tick(68);
    chk3("at17", 5'd17, 2'b01, 1'b0);
    bus.btn_desce = 1'b1;
    tick(1);
    bus.btn_desce = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk3("rst_mid", 5'd0, 2'b00, 1'b0);
    tick(4);
    chk3("rst_lost_ev", 5'd0, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
